// File: rtl/mempool_pkg.sv
// Shared MemPool types: DMA request layout, DRAM controller index type,
// L1 (TCDM) address range and the burst splitter FSM encoding.
package mempool_pkg;

    localparam int unsigned NumDramsCfg = 4;
    localparam logic [31:0] L1Base      = 32'h0000_0000;
    localparam logic [31:0] TCDMSize    = 32'h0010_0000;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef logic [idx_width(NumDramsCfg)-1:0] dram_id_t;

    typedef struct packed {
        logic [31:0] src;
        logic [31:0] dst;
        logic [31:0] num_bytes;
        logic        decouple_rw;
        logic        deburst;
        logic        serialize;
    } dma_req_t;

    typedef enum logic {
        IDLE,
        SPLIT
    } split_state_e;

endpackage

// File: rtl/dram_boundary_calc.sv
// Combinational sub-burst sizing: largest chunk that stays inside one
// interleave chunk on both sides, plus the L2-side controller index.
module dram_boundary_calc
    import mempool_pkg::*;
#(
    parameter int unsigned NumDrams        = 4,
    parameter int unsigned InterleaveBytes = 1024,
    parameter logic [31:0] L1Size          = TCDMSize
) (
    input  logic [31:0]                    src,
    input  logic [31:0]                    dst,
    input  logic [31:0]                    rem,
    output logic [31:0]                    len,
    output logic                           last,
    output logic [idx_width(NumDrams)-1:0] dram_id
);

    localparam int unsigned IdW    = idx_width(NumDrams);
    localparam int unsigned OffW   = $clog2(InterleaveBytes);
    localparam logic [31:0] Chunk  = 32'(InterleaveBytes);
    localparam logic [31:0] Mask   = 32'(InterleaveBytes - 1);

    logic [31:0] src_room;
    logic [31:0] dst_room;
    logic [31:0] l2_addr;

    always_comb begin
        src_room = Chunk - (src & Mask);
        dst_room = Chunk - (dst & Mask);
        len      = rem;
        if (src_room < len) len = src_room;
        if (dst_room < len) len = dst_room;
        last     = (len == rem);
        // The L2 side is src unless src lives in L1.
        l2_addr  = (src >= L1Size) ? src : dst;
        dram_id  = (NumDrams == 1) ? '0 : IdW'(l2_addr >> OffW);
    end

endmodule

// File: rtl/dram_burst_splitter.sv
// Splits DMA requests into sub-bursts that never cross a DRAM interleave boundary.
// Optional perf counters: define DRAM_BURST_SPLITTER_PERF_EN.
module dram_burst_splitter
    import mempool_pkg::*;
#(
    parameter int unsigned NumDrams        = 4,
    parameter int unsigned InterleaveBytes = 1024,
    parameter logic [31:0] L1Size          = TCDMSize
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  dma_req_t                       req_i,
    input  logic                           req_valid_i,
    output logic                           req_ready_o,
    output dma_req_t                       burst_o,
    output logic                           burst_valid_o,
    input  logic                           burst_ready_i,
    output logic [idx_width(NumDrams)-1:0] burst_dram_id_o,
    output logic                           burst_last_o,
    output logic                           busy_o
`ifdef DRAM_BURST_SPLITTER_PERF_EN
    ,
    output logic [31:0]                    perf_bursts_o,
    output logic [31:0]                    perf_reqs_o
`endif
);

    split_state_e state_q;
    dma_req_t     req_q;
    logic [31:0]  src_q;
    logic [31:0]  dst_q;
    logic [31:0]  rem_q;
    logic [31:0]  len;
    logic         calc_last;

    dram_boundary_calc #(
        .NumDrams        (NumDrams),
        .InterleaveBytes (InterleaveBytes),
        .L1Size          (L1Size)
    ) u_calc (
        .src     (src_q),
        .dst     (dst_q),
        .rem     (rem_q),
        .len     (len),
        .last    (calc_last),
        .dram_id (burst_dram_id_o)
    );

    always_comb begin
        burst_o           = req_q;
        burst_o.src       = src_q;
        burst_o.dst       = dst_q;
        burst_o.num_bytes = len;
    end

    // rem is 0 outside SPLIT, so the raw last flag must be qualified by valid.
    assign burst_last_o = burst_valid_o & calc_last;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            req_q         <= '0;
            src_q         <= '0;
            dst_q         <= '0;
            rem_q         <= '0;
            req_ready_o   <= 1'b1;
            burst_valid_o <= 1'b0;
            busy_o        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid_i && req_ready_o) begin
                        req_q <= req_i;
                        src_q <= req_i.src;
                        dst_q <= req_i.dst;
                        rem_q <= req_i.num_bytes;
                        if (req_i.num_bytes != '0) begin
                            state_q       <= SPLIT;
                            req_ready_o   <= 1'b0;
                            burst_valid_o <= 1'b1;
                            busy_o        <= 1'b1;
                        end
                    end
                end
                SPLIT: begin
                    if (burst_ready_i) begin
                        src_q <= src_q + len;
                        dst_q <= dst_q + len;
                        rem_q <= rem_q - len;
                        if (calc_last) begin
                            state_q       <= IDLE;
                            req_ready_o   <= 1'b1;
                            burst_valid_o <= 1'b0;
                            busy_o        <= 1'b0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef DRAM_BURST_SPLITTER_PERF_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_bursts_o <= '0;
            perf_reqs_o   <= '0;
        end else begin
            if (state_q == SPLIT && burst_ready_i)
                perf_bursts_o <= perf_bursts_o + 32'd1;
            if (state_q == IDLE && req_valid_i && req_i.num_bytes != '0)
                perf_reqs_o <= perf_reqs_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dram_burst_splitter.sv
// Scoreboard bench for dram_burst_splitter: directed requests push expected
// sub-bursts; a negedge monitor pops and compares on every burst handshake.
module tb_dram_burst_splitter;
    import mempool_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    dma_req_t   req_i;
    logic       req_valid_i;
    logic       req_ready_o;
    dma_req_t   burst_o;
    logic       burst_valid_o;
    logic       burst_ready_i;
    logic [1:0] burst_dram_id_o;
    logic       burst_last_o;
    logic       busy_o;
`ifdef DRAM_BURST_SPLITTER_PERF_EN
    logic [31:0] perf_bursts_o;
    logic [31:0] perf_reqs_o;
`endif

    always #5 clk = ~clk;

    dram_burst_splitter #(
        .NumDrams        (4),
        .InterleaveBytes (1024),
        .L1Size          (TCDMSize)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .req_i           (req_i),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .burst_o         (burst_o),
        .burst_valid_o   (burst_valid_o),
        .burst_ready_i   (burst_ready_i),
        .burst_dram_id_o (burst_dram_id_o),
        .burst_last_o    (burst_last_o),
        .busy_o          (busy_o)
`ifdef DRAM_BURST_SPLITTER_PERF_EN
        ,
        .perf_bursts_o   (perf_bursts_o),
        .perf_reqs_o     (perf_reqs_o)
`endif
    );

    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        logic [31:0] len;
        logic [2:0]  flags;
        logic [1:0]  id;
        logic        last;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned hs_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    endtask

    task automatic push(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l,
                        input logic [2:0] f, input logic [1:0] id, input logic last);
        exp_t e;
        e.src = s; e.dst = d; e.len = l; e.flags = f; e.id = id; e.last = last;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!rst && burst_valid_o && burst_ready_i) begin
            hs_count++;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_burst: got src 0x%0h, expected no burst", burst_o.src);
            end else begin
                mon_e = exp_q.pop_front();
                check("burst_src", burst_o.src, mon_e.src);
                check("burst_dst", burst_o.dst, mon_e.dst);
                check("burst_len", burst_o.num_bytes, mon_e.len);
                check("burst_flags", {29'd0, burst_o.decouple_rw, burst_o.deburst, burst_o.serialize},
                      {29'd0, mon_e.flags});
                check("burst_id", {30'd0, burst_dram_id_o}, {30'd0, mon_e.id});
                check("burst_last", {31'd0, burst_last_o}, {31'd0, mon_e.last});
            end
        end
    end

    task automatic issue(input logic [31:0] s, input logic [31:0] d, input logic [31:0] nb,
                         input logic [2:0] f);
        int unsigned t = 0;
        while (!req_ready_o && t < 50) begin
            @(posedge clk); #1; t++;
        end
        if (!req_ready_o) begin
            n_checks++;
            $display("FAIL req_ready_timeout: got 0, expected 1 within 50 cycles");
        end
        req_i = '{src: s, dst: d, num_bytes: nb, decouple_rw: f[2], deburst: f[1], serialize: f[0]};
        req_valid_i = 1'b1;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        req_i = '0;
    endtask

    task automatic drain(input string name);
        int unsigned t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(posedge clk); #1; t++;
        end
        check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
        check({name, "_idle_busy"}, {31'd0, busy_o}, 32'd0);
        check({name, "_idle_ready"}, {31'd0, req_ready_o}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1);
    end

    initial begin
        int unsigned hs0;
        rst = 1'b1; req_valid_i = 1'b0; req_i = '0; burst_ready_i = 1'b1;
        #1;
        check("rst_valid", {31'd0, burst_valid_o}, 32'd0);
        check("rst_last", {31'd0, burst_last_o}, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_src", burst_o.src, 32'd0);
        check("rst_len", burst_o.num_bytes, 32'd0);
        check("rst_id", {30'd0, burst_dram_id_o}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_ready", {31'd0, req_ready_o}, 32'd1);

        // 1: aligned, L2 source
        push(32'h8000_0000, 32'h0000_1000, 32'h400, 3'b010, 2'd0, 1'b0);
        push(32'h8000_0400, 32'h0000_1400, 32'h400, 3'b010, 2'd1, 1'b1);
        issue(32'h8000_0000, 32'h0000_1000, 32'h800, 3'b010);
        check("s1_latency", {31'd0, burst_valid_o}, 32'd1);
        check("s1_busy", {31'd0, busy_o}, 32'd1);
        check("s1_ready_low", {31'd0, req_ready_o}, 32'd0);
        drain("s1");

        // 2: unaligned source crossing a boundary
        push(32'h8000_03F0, 32'h0000_0100, 32'h10, 3'b101, 2'd0, 1'b0);
        push(32'h8000_0400, 32'h0000_0110, 32'h10, 3'b101, 2'd1, 1'b1);
        issue(32'h8000_03F0, 32'h0000_0100, 32'h20, 3'b101);
        drain("s2");

        // 3: L1 source, L2 destination in controller 3
        push(32'h0000_0000, 32'h8000_0C00, 32'h10, 3'b000, 2'd3, 1'b1);
        issue(32'h0000_0000, 32'h8000_0C00, 32'h10, 3'b000);
        drain("s3");

        // 4: zero-length request is consumed silently
        issue(32'h8000_0000, 32'h0000_2000, 32'h0, 3'b111);
        for (int i = 0; i < 3; i++) begin
            check("s4_valid", {31'd0, burst_valid_o}, 32'd0);
            check("s4_busy", {31'd0, busy_o}, 32'd0);
            check("s4_ready", {31'd0, req_ready_o}, 32'd1);
            @(posedge clk); #1;
        end

        // 5: backpressure on scenario 1
        burst_ready_i = 1'b0;
        hs0 = hs_count;
        push(32'h8000_0000, 32'h0000_1000, 32'h400, 3'b010, 2'd0, 1'b0);
        push(32'h8000_0400, 32'h0000_1400, 32'h400, 3'b010, 2'd1, 1'b1);
        issue(32'h8000_0000, 32'h0000_1000, 32'h800, 3'b010);
        for (int i = 0; i < 5; i++) begin
            check("s5_valid", {31'd0, burst_valid_o}, 32'd1);
            check("s5_src", burst_o.src, 32'h8000_0000);
            check("s5_dst", burst_o.dst, 32'h0000_1000);
            check("s5_len", burst_o.num_bytes, 32'h400);
            check("s5_id", {30'd0, burst_dram_id_o}, 32'd0);
            check("s5_last", {31'd0, burst_last_o}, 32'd0);
            @(posedge clk); #1;
        end
        burst_ready_i = 1'b1;
        drain("s5");
        check("s5_handshakes", 32'(hs_count - hs0), 32'd2);

        // 6: reset after the first burst of scenario 1
        push(32'h8000_0000, 32'h0000_1000, 32'h400, 3'b010, 2'd0, 1'b0);
        push(32'h8000_0400, 32'h0000_1400, 32'h400, 3'b010, 2'd1, 1'b1);
        issue(32'h8000_0000, 32'h0000_1000, 32'h800, 3'b010);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("s6_pending", 32'(exp_q.size()), 32'd1);
        check("s6_valid", {31'd0, burst_valid_o}, 32'd0);
        check("s6_last", {31'd0, burst_last_o}, 32'd0);
        check("s6_busy", {31'd0, busy_o}, 32'd0);
        check("s6_src", burst_o.src, 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        check("s6_ready", {31'd0, req_ready_o}, 32'd1);
        check("s6_valid_after", {31'd0, burst_valid_o}, 32'd0);
`ifdef DRAM_BURST_SPLITTER_PERF_EN
        check("s6_perf_bursts", perf_bursts_o, 32'd0);
        check("s6_perf_reqs", perf_reqs_o, 32'd0);
`endif
        @(posedge clk); #1;
        check("s6_no_replay", {31'd0, burst_valid_o}, 32'd0);

        // recovery after reset
        push(32'h0000_0000, 32'h8000_0C00, 32'h10, 3'b000, 2'd3, 1'b1);
        issue(32'h0000_0000, 32'h8000_0C00, 32'h10, 3'b000);
        drain("s7");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
